// File: rtl/bit_count_accum.sv
// bit_count_accum: reduces FRAME_LEN popcount results into frame statistics
// (sum, max, min, zero tally, clamp error) and presents each frame on valid/ready.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   clear           synchronous flush of the partial or held frame
//   in_valid/ready  popcount result handshake, in_count is the result
//   out_valid/ready frame statistics handshake
//   out_sum/max/min/zero/err  statistics of the last completed frame
module bit_count_accum #(
    parameter int WIDTH      = 16,
    parameter int FRAME_LEN  = 8,
    localparam int CW = $clog2(WIDTH + 1),
    localparam int SW = $clog2(WIDTH * FRAME_LEN + 1),
    localparam int ZW = $clog2(FRAME_LEN + 1),
    localparam int IW = $clog2(FRAME_LEN)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          in_valid,
    input  logic [CW-1:0] in_count,
    output logic          in_ready,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [SW-1:0] out_sum,
    output logic [CW-1:0] out_max,
    output logic [CW-1:0] out_min,
    output logic [ZW-1:0] out_zero,
    output logic          out_err
);

    typedef enum logic {ACCUM, HOLD} state_t;

    localparam logic [CW-1:0] WMAX = CW'(WIDTH);
    localparam logic [IW-1:0] LAST = IW'(FRAME_LEN - 1);

    state_t        state_q, state_d;
    logic [IW-1:0] idx;
    logic [SW-1:0] acc_sum;
    logic [CW-1:0] acc_max, acc_min;
    logic [ZW-1:0] acc_zero;
    logic          acc_err;

    logic          accept, last, first, clamp;
    logic [CW-1:0] v;
    logic [SW-1:0] n_sum;
    logic [CW-1:0] n_max, n_min;
    logic [ZW-1:0] n_zero;
    logic          n_err;

    assign in_ready  = (state_q == ACCUM);
    assign out_valid = (state_q == HOLD);
    assign accept    = in_valid & in_ready;
    assign last      = (idx == LAST);
    assign first     = (idx == '0);

    // Out-of-range results are clamped to WIDTH and flagged.
    assign clamp = (in_count > WMAX);
    assign v     = clamp ? WMAX : in_count;

    // The first result of a frame seeds the accumulators instead of
    // combining with stale values from the previous frame.
    always_comb begin
        n_sum  = first ? SW'(v) : acc_sum + SW'(v);
        n_max  = acc_max;
        n_min  = acc_min;
        n_zero = (first ? '0 : acc_zero) + ZW'(v == '0);
        n_err  = (first ? 1'b0 : acc_err) | clamp;
        if (first || v > acc_max) n_max = v;
        if (first || v < acc_min) n_min = v;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ACCUM: if (accept && last) state_d = HOLD;
            HOLD:  if (out_ready) state_d = ACCUM;
        endcase
        if (clear) state_d = ACCUM;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ACCUM;
            idx      <= '0;
            acc_sum  <= '0;
            acc_max  <= '0;
            acc_min  <= '0;
            acc_zero <= '0;
            acc_err  <= 1'b0;
            out_sum  <= '0;
            out_max  <= '0;
            out_min  <= '0;
            out_zero <= '0;
            out_err  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (clear) begin
                idx <= '0;
                if (state_q == HOLD) begin
                    out_sum  <= '0;
                    out_max  <= '0;
                    out_min  <= '0;
                    out_zero <= '0;
                    out_err  <= 1'b0;
                end
            end else if (accept) begin
                acc_sum  <= n_sum;
                acc_max  <= n_max;
                acc_min  <= n_min;
                acc_zero <= n_zero;
                acc_err  <= n_err;
                idx      <= last ? '0 : idx + IW'(1);
                if (last) begin
                    out_sum  <= n_sum;
                    out_max  <= n_max;
                    out_min  <= n_min;
                    out_zero <= n_zero;
                    out_err  <= n_err;
                end
            end
        end
    end

endmodule

// File: tb/tb_bit_count_accum.sv
// tb_bit_count_accum: directed frame vectors plus multi-cycle corner
// sequences (stall, clear, reset, full throughput) for bit_count_accum.
module tb_bit_count_accum;

    localparam int WIDTH = 8;
    localparam int FLEN  = 4;
    localparam int CW    = 4;
    localparam int SW    = 6;
    localparam int ZW    = 3;

    logic          clk = 1'b0;
    logic          rst, clear, in_valid, in_ready, out_valid, out_ready;
    logic [CW-1:0] in_count;
    logic [SW-1:0] out_sum;
    logic [CW-1:0] out_max, out_min;
    logic [ZW-1:0] out_zero;
    logic          out_err;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        int c[4];
        int sum;
        int mx;
        int mn;
        int zero;
        int err;
    } vec_t;

    vec_t tbl[7];

    bit_count_accum #(.WIDTH(WIDTH), .FRAME_LEN(FLEN)) dut (
        .clk(clk), .rst(rst), .clear(clear),
        .in_valid(in_valid), .in_count(in_count), .in_ready(in_ready),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_max(out_max), .out_min(out_min),
        .out_zero(out_zero), .out_err(out_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    function automatic vec_t mk(int a, int b, int c, int d,
                                int s, int mx, int mn, int z, int e);
        vec_t r;
        r.c[0] = a; r.c[1] = b; r.c[2] = c; r.c[3] = d;
        r.sum = s; r.mx = mx; r.mn = mn; r.zero = z; r.err = e;
        return r;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s act=%0d exp=%0d", name, act, exp);
        end
    endtask

    // Called just after a negedge; returns just after the negedge
    // following the accepting posedge, leaving in_valid high.
    task automatic push(input int c);
        int n = 0;
        in_valid = 1'b1;
        in_count = CW'(c);
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("push_ready", int'(in_ready), 1);
        @(negedge clk);
    endtask

    task automatic check_out(input string tag, input vec_t v);
        chk({tag, ".valid"}, int'(out_valid), 1);
        chk({tag, ".sum"},   int'(out_sum),   v.sum);
        chk({tag, ".max"},   int'(out_max),   v.mx);
        chk({tag, ".min"},   int'(out_min),   v.mn);
        chk({tag, ".zero"},  int'(out_zero),  v.zero);
        chk({tag, ".err"},   int'(out_err),   v.err);
    endtask

    task automatic handshake(input string tag);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, ".hs_in_ready"},  int'(in_ready),  1);
        chk({tag, ".hs_out_valid"}, int'(out_valid), 0);
    endtask

    task automatic run_frame(input string tag, input vec_t v);
        out_ready = 1'b0;
        for (int k = 0; k < FLEN; k++) push(v.c[k]);
        in_valid = 1'b0;
        check_out(tag, v);
        handshake(tag);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, ".valid"}, int'(out_valid), 0);
        chk({tag, ".sum"},   int'(out_sum),   0);
        chk({tag, ".max"},   int'(out_max),   0);
        chk({tag, ".min"},   int'(out_min),   0);
        chk({tag, ".zero"},  int'(out_zero),  0);
        chk({tag, ".err"},   int'(out_err),   0);
    endtask

    initial begin
        int t0, t1;
        vec_t f;

        tbl[0] = mk(3, 0, 8, 1,  12, 8, 0, 1, 0);
        tbl[1] = mk(2, 2, 2, 2,   8, 2, 2, 0, 0);
        tbl[2] = mk(7, 9, 0, 0,  15, 8, 0, 2, 1);
        tbl[3] = mk(1, 1, 1, 1,   4, 1, 1, 0, 0);
        tbl[4] = mk(0, 0, 0, 0,   0, 0, 0, 4, 0);
        tbl[5] = mk(15, 8, 8, 8, 32, 8, 8, 0, 1);
        tbl[6] = mk(5, 6, 5, 4,  20, 6, 4, 0, 0);

        rst = 1'b1; clear = 1'b0; in_valid = 1'b0;
        in_count = '0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check_zero("reset");
        chk("reset.in_ready", int'(in_ready), 1);
        rst = 1'b0;
        @(negedge clk);

        // Held frame is stable under backpressure; in_valid ignored.
        for (int k = 0; k < FLEN; k++) push(tbl[0].c[k]);
        in_valid = 1'b0;
        check_out("stall0", tbl[0]);
        for (int i = 0; i < 5; i++) begin
            in_valid = (i % 2 == 0);
            in_count = 4'd5;
            chk("stall.in_ready",  int'(in_ready),  0);
            chk("stall.out_valid", int'(out_valid), 1);
            chk("stall.sum",       int'(out_sum),   12);
            chk("stall.min",       int'(out_min),   0);
            @(negedge clk);
        end
        in_valid = 1'b0;
        check_out("stall1", tbl[0]);
        handshake("stall");
        run_frame("after_stall", tbl[1]);

        for (int i = 0; i < 7; i++)
            run_frame($sformatf("vec%0d", i), tbl[i]);

        // Clear in ACCUM discards partial frame; wins over accept.
        push(5);
        push(5);
        in_count = 4'd7;
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        in_valid = 1'b0;
        run_frame("clear_accum", tbl[3]);

        // Clear in HOLD drops the frame and zeroes outputs.
        for (int k = 0; k < FLEN; k++) push(3);
        in_valid = 1'b0;
        chk("clear_hold.pre_valid", int'(out_valid), 1);
        chk("clear_hold.pre_sum", int'(out_sum), 12);
        clear = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        out_ready = 1'b0;
        check_zero("clear_hold");
        chk("clear_hold.in_ready", int'(in_ready), 1);

        // Mid-frame reset after a completed frame.
        run_frame("pre_rst", tbl[6]);
        push(4); push(4); push(4);
        in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_zero("rst_mid");
        for (int k = 0; k < 3; k++) begin
            push(6);
            chk("rst_mid.wait_valid", int'(out_valid), 0);
            chk("rst_mid.wait_sum",   int'(out_sum),   0);
        end
        push(6);
        in_valid = 1'b0;
        f = mk(6, 6, 6, 6, 24, 6, 6, 0, 0);
        check_out("rst_frame", f);

        // Reset while holding a frame.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_zero("rst_hold");
        chk("rst_hold.in_ready", int'(in_ready), 1);

        // Full throughput: one frame every FLEN+1 cycles.
        out_ready = 1'b1;
        t0 = 0;
        for (int fr = 0; fr < 3; fr++) begin
            f = (fr == 0) ? tbl[0] : (fr == 1) ? tbl[6] : tbl[2];
            for (int k = 0; k < FLEN; k++) push(f.c[k]);
            check_out($sformatf("tput%0d", fr), f);
            t1 = cyc;
            if (fr > 0) chk("tput.period", t1 - t0, FLEN + 1);
            t0 = t1;
        end
        in_valid = 1'b0;
        @(negedge clk);
        out_ready = 1'b0;
        chk("tput.end_valid", int'(out_valid), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
